// File: rtl/adder_pkg.sv
// Shared configuration for the pipelined adder: default sizes, slice-width helper
// and the legality check used at elaboration.
package adder_pkg;

  localparam int unsigned WIDTH_DEF  = 32;
  localparam int unsigned STAGES_DEF = 4;

  function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

  // WIDTH must split into STAGES equal, non-empty slices.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple-carry slice built from per-bit full adders.
module adder_slice #(
  parameter int unsigned SW = 8
) (
  input  logic [SW-1:0] x_i,
  input  logic [SW-1:0] y_i,
  input  logic          c_i,
  output logic [SW-1:0] s_o,
  output logic          c_o
);

  logic [SW:0] carry;

  always_comb begin
    carry    = '0;
    s_o      = '0;
    carry[0] = c_i;
    for (int unsigned i = 0; i < SW; i++) begin
      s_o[i]     = x_i[i] ^ y_i[i] ^ carry[i];
      carry[i+1] = (x_i[i] & y_i[i]) | (x_i[i] & carry[i]) | (y_i[i] & carry[i]);
    end
  end

  assign c_o = carry[SW];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: STAGES carry slices, one register stage each, valid/ready
// on both sides. Define PIPE_ADD_OVF_EN to add the signed-overflow output ovf.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned STAGES = STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SW = slice_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  // Whole pipeline moves as one; a stalled output freezes every stage.
  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned DONE_W = (k + 1) * SW;
    localparam int unsigned REM_W  = WIDTH - DONE_W;

    logic [SW-1:0]     x_c;
    logic [SW-1:0]     y_c;
    logic [SW-1:0]     s_c;
    logic              ci_c;
    logic              co_c;
    logic              v_c;
    logic [DONE_W-1:0] sum_d;
    logic [DONE_W-1:0] sum_q;
    logic              valid_q;
    logic              carry_q;

    // Operand slice, carry and finished low sum bits come from the inputs or the previous stage.
    if (k == 0) begin : g_head
      assign x_c   = a[SW-1:0];
      assign y_c   = b[SW-1:0];
      assign ci_c  = cin;
      assign v_c   = in_valid;
      assign sum_d = s_c;
    end else begin : g_head
      assign x_c   = g_stage[k-1].g_skew.a_q[SW-1:0];
      assign y_c   = g_stage[k-1].g_skew.b_q[SW-1:0];
      assign ci_c  = g_stage[k-1].carry_q;
      assign v_c   = g_stage[k-1].valid_q;
      assign sum_d = {s_c, g_stage[k-1].sum_q};
    end

    adder_slice #(
      .SW (SW)
    ) u_slice (
      .x_i (x_c),
      .y_i (y_c),
      .c_i (ci_c),
      .s_o (s_c),
      .c_o (co_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        valid_q <= v_c;
        carry_q <= co_c;
        sum_q   <= sum_d;
      end
    end

    // Skew registers carry the operand slices later stages have yet to add.
    if (k + 1 < STAGES) begin : g_skew
      logic [REM_W-1:0] a_d;
      logic [REM_W-1:0] b_d;
      logic [REM_W-1:0] a_q;
      logic [REM_W-1:0] b_q;

      if (k == 0) begin : g_src
        assign a_d = a[WIDTH-1:SW];
        assign b_d = b[WIDTH-1:SW];
      end else begin : g_src
        assign a_d = g_stage[k-1].g_skew.a_q[REM_W+SW-1:SW];
        assign b_d = g_stage[k-1].g_skew.b_q[REM_W+SW-1:SW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

`ifdef PIPE_ADD_OVF_EN
    // The top slice sees the operand sign bits, so overflow is registered alongside the sum.
    if (k + 1 == STAGES) begin : g_ovf
      logic ovf_d;
      logic ovf_q;

      assign ovf_d = (x_c[SW-1] == y_c[SW-1]) && (s_c[SW-1] != x_c[SW-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].carry_q;

`ifdef PIPE_ADD_OVF_EN
  assign ovf = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=8; STAGES=2, or 4 when PIPE_ADD_OVF_EN is defined).
module tb_pipelined_adder;

  localparam int unsigned WIDTH = 8;
`ifdef PIPE_ADD_OVF_EN
  localparam int unsigned STAGES = 4;
`else
  localparam int unsigned STAGES = 2;
`endif
  localparam int unsigned NVEC = 18;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPE_ADD_OVF_EN
  logic             ovf;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // a, b, cin, sum, cout, ovf -- expected values worked out by hand
  vec_t vecs [NVEC] = '{
    '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0},
    '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0},
    '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0},
    '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
    '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
    '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0},
    '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0},
    '{8'h01, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0},
    '{8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0},
    '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 1'b0},
    '{8'h99, 8'h66, 1'b1, 8'h00, 1'b1, 1'b0},
    '{8'h5A, 8'h5A, 1'b0, 8'hB4, 1'b0, 1'b1},
    '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0},
    '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0},
    '{8'h0E, 8'h02, 1'b1, 8'h11, 1'b0, 1'b0},
    '{8'hFE, 8'hFE, 1'b1, 8'hFD, 1'b1, 1'b0},
    '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1},
    '{8'h05, 8'hFE, 1'b0, 8'h03, 1'b1, 1'b0}
  };

  int bp_idx [4] = '{16, 17, 2, 3};

  pipelined_adder #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPE_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Called at posedge+1; holds the operands until accepted, then queues the expected result.
  task automatic send(input vec_t v, input bit need_ready, input string tag);
    int unsigned guard = 0;
    bit          acc   = 1'b0;
    a        = v.a;
    b        = v.b;
    cin      = v.cin;
    in_valid = 1'b1;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      if (need_ready) chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (acc) begin
      exp_q.push_back('{v.sum, v.cout, v.ovf});
    end else begin
      checks++;
      errors++;
      $display("FAIL %s_accept: operand not accepted within %0d cycles", tag, guard);
    end
  endtask

  task automatic wait_drain(input string tag);
    int unsigned guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops and compares whenever a result transfers out.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got sum 0x%0h cout %0b with no pending operation", sum, cout);
        end else begin
          e = exp_q.pop_front();
          chk("result_sum", 32'(sum), 32'(e.sum));
          chk("result_cout", 32'(cout), 32'(e.cout));
`ifdef PIPE_ADD_OVF_EN
          chk("result_ovf", 32'(ovf), 32'(e.ovf));
`endif
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : main
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_ADD_OVF_EN
    chk("reset_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single operation: result must appear exactly STAGES cycles after acceptance.
    send(vecs[0], 1'b1, "basic");
    for (int i = 1; i < STAGES; i++) begin
      chk("latency_early", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("latency_due", 32'(out_valid), 32'd1);
    wait_drain("basic");

    // Back-to-back stream with the sink always ready.
    for (int i = 0; i < 16; i++) send(vecs[i], 1'b1, "stream");
    wait_drain("stream");

    // Fill the pipeline against a stalled sink, then hold an extra operand at the input.
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) send(vecs[bp_idx[i]], 1'b1, "fill");
    fork
      send(vecs[5], 1'b0, "blocked");
      begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_out_valid", 32'(out_valid), 32'd1);
          chk("stall_sum", 32'(sum), 32'(vecs[16].sum));
          chk("stall_cout", 32'(cout), 32'(vecs[16].cout));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("backpressure");

    // Reset with two operations in flight: nothing from them may ever emerge.
    out_ready = 1'b0;
    send(vecs[6], 1'b1, "pre_reset");
    send(vecs[7], 1'b1, "pre_reset");
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_sum", 32'(sum), 32'd0);
    chk("midreset_cout", 32'(cout), 32'd0);
`ifdef PIPE_ADD_OVF_EN
    chk("midreset_ovf", 32'(ovf), 32'd0);
`endif
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (2 * STAGES + 2) begin
      @(negedge clk);
      chk("post_reset_idle", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(vecs[8], 1'b1, "post_reset");
    wait_drain("post_reset");

    repeat (STAGES + 2) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_out_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
